// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV32I control unit: FSM state enum,
// RV32I opcode values, immediate-extender select codes, ALU operation codes
// and the operation class handed to the ALU decoder.
// ----------------------------------------------------------------------------
package ctrl_pkg;

  // Controller states (16 states fill a 4-bit encoding exactly)
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_JALR_WB = 4'd12,
    S_LUI     = 4'd13,
    S_AUIPC   = 4'd14,
    S_TRAP    = 4'd15
  } state_e;

  // Operation class selecting how the ALU decoder interprets funct fields
  typedef enum logic [1:0] {
    ACLS_ADD = 2'd0,
    ACLS_SUB = 2'd1,
    ACLS_R   = 2'd2,
    ACLS_I   = 2'd3
  } alu_class_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Immediate extender selects
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Immediate format for an opcode; R-type and unknown opcodes give I (000)
  function automatic logic [2:0] imm_src_f(input logic [6:0] opcode);
    logic [2:0] sel;
    case (opcode)
      OPC_STORE:          sel = IMM_S;
      OPC_BRANCH:         sel = IMM_B;
      OPC_LUI, OPC_AUIPC: sel = IMM_U;
      OPC_JAL:            sel = IMM_J;
      default:            sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational mapping from (operation class, funct3, funct7[5]) to the ALU
// operation code.
//   class_i     : ADD / SUB force the operation; R / I decode funct fields
//   funct3_i    : instr[14:12]
//   funct7b5_i  : instr[30]
//   alu_ctrl_o  : ALU operation code
// ----------------------------------------------------------------------------
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_e  class_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  output logic [3:0]  alu_ctrl_o
);

  logic [3:0] alu_ctrl_s;

  // Operation select; funct7[5] only distinguishes SUB (R-type) and SRA
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (class_i)
      ACLS_ADD: alu_ctrl_s = ALU_ADD;
      ACLS_SUB: alu_ctrl_s = ALU_SUB;
      ACLS_R, ACLS_I: begin
        case (funct3_i)
          3'b000: begin
            // ADDI carries immediate bits in funct7, so never SUB for I-type
            if ((class_i == ACLS_R) && funct7b5_i) alu_ctrl_s = ALU_SUB;
            else                                   alu_ctrl_s = ALU_ADD;
          end
          3'b001: alu_ctrl_s = ALU_SLL;
          3'b010: alu_ctrl_s = ALU_SLT;
          3'b011: alu_ctrl_s = ALU_SLTU;
          3'b100: alu_ctrl_s = ALU_XOR;
          3'b101: begin
            if (funct7b5_i) alu_ctrl_s = ALU_SRA;
            else            alu_ctrl_s = ALU_SRL;
          end
          3'b110: alu_ctrl_s = ALU_OR;
          3'b111: alu_ctrl_s = ALU_AND;
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = alu_ctrl_s;

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the multicycle RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback over one ALU, one unified memory port and the
// immediate extender, and handshakes with a variable-latency memory.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   instr_i            : latched instruction register
//   branch_taken_i     : comparator result for the current branch
//   mem_ready_i        : memory completes the current request this cycle
//   mem_req_o, MemWrite_o, AdrSrc_o             : memory port control
//   IRWrite_o, PCWrite_o, RegWrite_o            : single-cycle write enables
//   ImmSrc_o, ALUSrcA_o, ALUSrcB_o, ALUControl_o, ResultSrc_o : datapath selects
//   illegal_o          : sticky, an unsupported opcode was decoded
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_ready_i,
  output logic                  mem_req_o,
  output logic                  MemWrite_o,
  output logic                  AdrSrc_o,
  output logic                  IRWrite_o,
  output logic                  PCWrite_o,
  output logic                  RegWrite_o,
  output logic [2:0]            ImmSrc_o,
  output logic [1:0]            ALUSrcA_o,
  output logic [1:0]            ALUSrcB_o,
  output logic [3:0]            ALUControl_o,
  output logic [1:0]            ResultSrc_o,
  output logic                  illegal_o
);

  state_e     state_q, state_d;
  logic       illegal_q;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       funct7b5_s;
  logic       unused_instr_s;

  alu_class_e alu_class_s;
  logic [3:0] alu_ctrl_s;

  logic       mem_req_s, mem_write_s, adr_src_s;
  logic       ir_write_s, pc_write_s, reg_write_s;
  logic [1:0] src_a_s, src_b_s, result_src_s;

  assign opcode_s   = instr_i[6:0];
  assign funct3_s   = instr_i[14:12];
  assign funct7b5_s = instr_i[30];
  // Register indices and remaining immediate bits are datapath-only
  assign unused_instr_s = ^{instr_i[DATA_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

  alu_decoder u_alu_decoder (
    .class_i    (alu_class_s),
    .funct3_i   (funct3_s),
    .funct7b5_i (funct7b5_s),
    .alu_ctrl_o (alu_ctrl_s)
  );

  // Next-state and Moore control decode, with the ready/taken gated enables
  always_comb begin
    state_d      = state_q;
    mem_req_s    = 1'b0;
    mem_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    src_a_s      = 2'b00;
    src_b_s      = 2'b00;
    result_src_s = 2'b00;
    alu_class_s  = ACLS_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        src_b_s      = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready_i;
        pc_write_s   = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
        else             state_d = S_FETCH;
      end
      S_DECODE: begin
        src_a_s = 2'b01;
        src_b_s = 2'b01;
        case (opcode_s)
          OPC_LOAD, OPC_STORE: state_d = S_MEMADR;
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OPIMM:           state_d = S_EXEC_I;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_JALR:            state_d = S_JALR;
          OPC_LUI:             state_d = S_LUI;
          OPC_AUIPC:           state_d = S_AUIPC;
          default:             state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        // Only load/store reach here; bit 5 separates STORE from LOAD
        if (opcode_s[5]) state_d = S_MEMWR;
        else             state_d = S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
        else             state_d = S_MEMRD;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src_s   = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
        else             state_d = S_MEMWR;
      end
      S_EXEC_R: begin
        src_a_s     = 2'b10;
        src_b_s     = 2'b00;
        alu_class_s = ACLS_R;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_s     = 2'b10;
        src_b_s     = 2'b01;
        alu_class_s = ACLS_I;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_s = 2'b00;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b00;
        alu_class_s  = ACLS_SUB;
        result_src_s = 2'b00;
        pc_write_s   = branch_taken_i;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target computed in DECODE; ALU forms OldPC+4 for rd
        src_a_s      = 2'b01;
        src_b_s      = 2'b10;
        result_src_s = 2'b00;
        pc_write_s   = 1'b1;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        src_a_s      = 2'b10;
        src_b_s      = 2'b01;
        result_src_s = 2'b10;
        pc_write_s   = 1'b1;
        state_d      = S_JALR_WB;
      end
      S_JALR_WB: begin
        src_a_s      = 2'b01;
        src_b_s      = 2'b10;
        result_src_s = 2'b10;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_LUI: begin
        src_a_s = 2'b11;
        src_b_s = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a_s = 2'b01;
        src_b_s = 2'b01;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register and sticky illegal flag (set on entry to TRAP)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      else                   illegal_q <= illegal_q;
    end
  end

  // While reset is held every enable and select is forced low, even though
  // the state already reads FETCH; the fetch request appears on release.
  assign mem_req_o    = rst_ni & mem_req_s;
  assign MemWrite_o   = rst_ni & mem_write_s;
  assign AdrSrc_o     = rst_ni & adr_src_s;
  assign IRWrite_o    = rst_ni & ir_write_s;
  assign PCWrite_o    = rst_ni & pc_write_s;
  assign RegWrite_o   = rst_ni & reg_write_s;
  assign ImmSrc_o     = rst_ni ? imm_src_f(opcode_s) : 3'b000;
  assign ALUSrcA_o    = rst_ni ? src_a_s : 2'b00;
  assign ALUSrcB_o    = rst_ni ? src_b_s : 2'b00;
  assign ALUControl_o = rst_ni ? alu_ctrl_s : 4'b0000;
  assign ResultSrc_o  = rst_ni ? result_src_s : 2'b00;
  assign illegal_o    = illegal_q;

endmodule
